// File: rtl/wb_io_master.sv
// Wishbone pipelined-mode initiator: turns single CPU I/O requests into one bus
// cycle each, with an ack watchdog and a one-cycle response strobe.
module wb_io_master #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_dat,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_dat,
  output logic              rsp_err,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack,
  input  logic              wb_stall
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit               WDOG_EN  = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t              r_state;
  logic                r_cyc;
  logic                r_stb;
  logic                r_we;
  logic [ADDR_W-1:0]   r_adr;
  logic [DATA_W-1:0]   r_dat_o;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_dat;
  logic                r_rsp_err;
  logic [CNT_W-1:0]    r_cnt;

  logic w_busy;
  logic w_done;
  logic w_expire;

  // Ack only counts once the strobe has been transferred (stall low).
  assign w_busy   = (r_state != S_IDLE);
  assign w_done   = ((r_state == S_REQ) && !wb_stall && wb_ack) ||
                    ((r_state == S_WAIT) && wb_ack);
  assign w_expire = WDOG_EN && w_busy && (r_cnt == CNT_LAST);

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign wb_cyc    = r_cyc;
  assign wb_stb    = r_stb;
  assign wb_we     = r_we;
  assign wb_adr    = r_adr;
  assign wb_dat_o  = r_dat_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat_o     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_busy && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_adr   <= req_adr;
            r_dat_o <= req_we ? req_dat : '0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!wb_stall && !wb_ack) begin
            r_stb   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        default: ;
      endcase

      // Completion beats the watchdog when both land on the same edge.
      if (w_done) begin
        r_cyc       <= 1'b0;
        r_stb       <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b0;
        r_rsp_dat   <= r_we ? '0 : wb_dat_i;
        r_state     <= S_IDLE;
      end else if (w_expire) begin
        r_cyc       <= 1'b0;
        r_stb       <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_dat   <= '0;
        r_state     <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_wb_io_master.sv
// Randomized bench for wb_io_master: a transaction-level model predicts bus
// activity, response timing and result of each request from stall/ack timing.
module tb_wb_io_master;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int          TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic          rsp_valid;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack;
  logic          wb_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_io_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack   (wb_ack),
    .wb_stall (wb_stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One request; responder stalls s cycles, then acks d cycles after the transfer.
  // Ack inside the watchdog window (s+d < TO) completes, otherwise the cycle aborts.
  task automatic do_txn(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input int s, input int d, input logic [DW-1:0] rdata, input bit chain);
    bit            ok;
    int            last;
    logic [DW-1:0] exp_dat;
    ok      = (s + d) < TO;
    last    = ok ? (s + d + 1) : TO;
    exp_dat = (ok && !we) ? rdata : '0;
    check_eq("ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    wb_ack    = 1'b0;
    wb_stall  = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= last; k++) begin
      if (k < last) begin
        check_eq("ctl_busy", 64'({wb_cyc, wb_stb, rsp_valid, req_ready}),
                 64'({1'b1, (k <= s), 2'b00}));
        check_eq("bus", 64'({wb_we, wb_adr, wb_dat_o}),
                 64'({we, adr, (we ? dat : DW'(0))}));
        // Noise on the request side must be ignored while busy.
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_adr   = AW'($urandom);
        req_dat   = DW'($urandom);
        wb_stall  = (k < s);
        wb_ack    = (k == s + d) || ((k < s) && (1'($urandom_range(0, 1)) == 1'b1));
        wb_dat_i  = (k == s + d) ? rdata : DW'($urandom);
        @(negedge clk);
      end else begin
        check_eq("ctl_rsp", 64'({wb_cyc, wb_stb, rsp_valid, req_ready}), 64'(4'b0011));
        check_eq("rsp", 64'({rsp_err, rsp_dat}), 64'({~ok, exp_dat}));
      end
    end
    req_valid = 1'b0;
    wb_stall  = 1'b0;
    if (!chain) begin
      for (int j = 0; j < 2; j++) begin
        wb_ack   = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        wb_dat_i = DW'($urandom);
        @(negedge clk);
        check_eq("idle", 64'({wb_cyc, wb_stb, rsp_valid, req_ready}), 64'(4'b0001));
      end
    end
    wb_ack = 1'b0;
  endtask

  task automatic reset_mid_cycle();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_adr   = 16'h0ABC;
    req_dat   = 16'h5A5A;
    @(negedge clk);
    req_valid = 1'b0;
    wb_stall  = 1'b0;
    wb_ack    = 1'b0;
    @(negedge clk);
    check_eq("pre_rst", 64'({wb_cyc, wb_stb, rsp_valid, req_ready}), 64'(4'b1000));
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst", 64'({wb_cyc, wb_stb, wb_we, rsp_valid, req_ready, wb_adr, wb_dat_o}), 64'(0));
    rst      = 1'b0;
    wb_ack   = 1'b1;
    wb_dat_i = 16'hDEAD;
    @(negedge clk);
    check_eq("post_rst", 64'({wb_cyc, wb_stb, rsp_valid, req_ready}), 64'(4'b0001));
    wb_ack = 1'b0;
    @(negedge clk);
    check_eq("post_rst2", 64'({wb_cyc, wb_stb, rsp_valid, req_ready}), 64'(4'b0001));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_dat   = '0;
    wb_dat_i  = '0;
    wb_ack    = 1'b0;
    wb_stall  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset", 64'({wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, req_ready,
                           wb_adr, wb_dat_o, rsp_dat}),
             64'({5'b00000, 1'b1, 48'h0}));

    do_txn(1'b1, 16'h0010, 16'hBEEF, 0, 1, 16'h7777, 1'b0);   // write
    do_txn(1'b0, 16'h0020, 16'hFFFF, 0, 1, 16'h1234, 1'b0);   // read
    do_txn(1'b0, 16'h0030, 16'h0000, 3, 1, 16'hCAFE, 1'b0);   // stalled
    do_txn(1'b0, 16'h0040, 16'h0000, 0, 0, 16'h00A5, 1'b0);   // same-cycle ack
    do_txn(1'b0, 16'h0050, 16'h0000, 0, 100, 16'h1111, 1'b0); // never acks
    do_txn(1'b0, 16'h0060, 16'h0000, 0, TO - 1, 16'h2222, 1'b0); // ack on last cycle
    do_txn(1'b1, 16'h0070, 16'h3333, 0, TO, 16'h4444, 1'b0);  // ack one cycle late
    do_txn(1'b0, 16'h0080, 16'h0000, TO, 0, 16'h5555, 1'b0);  // stall through window

    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, AW'(i), 16'h0000, 0, 1, DW'(16'hA000 + i), (i != 3));
    end

    reset_mid_cycle();

    for (int i = 0; i < 60; i++) begin
      do_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
             $urandom_range(0, 4), $urandom_range(0, 9), DW'($urandom),
             (i != 59) && (1'($urandom_range(0, 1)) == 1'b1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_io_master.md
Name: wb_io_master

Overview:
- Wishbone pipelined-mode initiator that turns single I/O requests from the CPU side (J1 io read/write) into classic pipelined Wishbone bus cycles toward I/O responders.
- At most one outstanding transaction.
- Includes a watchdog that aborts cycles whose acknowledge never arrives.
- Returns read data, or an error flag, on a single-cycle response strobe.

Parameters:
- ADDR_W, 16, width of request and bus address
- DATA_W, 16, width of read/write data
- TIMEOUT, 255, cycles waited for ack after a cycle starts; 0 disables the watchdog

Ports:
- clk  input  1  clock (all logic on posedge)
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_we  input  1  1 = write, 0 = read
- req_adr  input  ADDR_W  request address
- req_dat  input  DATA_W  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_dat  output  DATA_W  read data (0 for writes and errors)
- rsp_err  output  1  valid with rsp_valid; 1 = timeout abort
- wb_cyc  output  1  Wishbone CYC
- wb_stb  output  1  Wishbone STB
- wb_we  output  1  Wishbone WE
- wb_adr  output  ADDR_W  Wishbone address
- wb_dat_o  output  DATA_W  Wishbone write data
- wb_dat_i  input  DATA_W  Wishbone read data
- wb_ack  input  1  Wishbone ACK
- wb_stall  input  1  Wishbone STALL

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; cyc, stb, we, rsp_valid and rsp_err = 0; adr, dat_o and rsp_dat = 0; timeout counter = 0. Reset overrides any cycle in progress; no response is issued for the aborted request.
- req_ready = (state == IDLE) & ~rst, combinational.
- States:
  - IDLE: on req_valid & req_ready, register adr/we/dat (dat_o = req_dat if write, else 0), cyc <= 1, stb <= 1, counter <= 0, go to REQ. Bus outputs appear the cycle after acceptance.
  - REQ (stb=1): a posedge with wb_stall=0 means the request has been transferred.
    - stall=0 & ack=0: stb <= 0, go to WAIT.
    - stall=0 & ack=1 (same-cycle responder): complete.
    - stall=1: hold all bus outputs stable. Any ack here is ignored (nothing outstanding).
  - WAIT (cyc=1, stb=0): ack=1 -> complete.
- Complete (registered): cyc <= 0, stb <= 0, rsp_valid <= 1, rsp_err <= 0, rsp_dat <= wb_dat_i if read else 0. Return to IDLE.
  - rsp_valid is high for exactly one cycle. A new request may be accepted in that same cycle.
- Watchdog (TIMEOUT > 0):
  - Counter increments each cycle in REQ or WAIT, saturating.
  - At a posedge where counter == TIMEOUT-1 and no completion occurs: cyc <= 0, stb <= 0, rsp_valid <= 1, rsp_err <= 1, rsp_dat <= 0, go to IDLE.
  - Ack on that same edge wins: normal completion.
  - A late ack arriving in IDLE is ignored.
- wb_we, wb_adr and wb_dat_o stay constant from bus-cycle start until cyc drops.
- Protocol guarantees: cyc never deasserts while stb=1 except on watchdog abort or reset. No response is ever issued without a prior accepted request.
- Latency with a zero-stall responder that registers ack (ack one cycle after the stb transfer):
  - accept at edge N;
  - stb high in cycle N+1;
  - ack in cycle N+2;
  - rsp_valid in cycle N+3.
  - Next request accepted at N+3 gives minimum throughput of one transaction per 3 cycles.

Test Plan:
- Write: req_we=1, adr=0x0010, dat=0xBEEF, registered-ack responder -> one stb cycle with we=1, adr=0x0010, dat_o=0xBEEF; rsp_valid 3 cycles after accept, rsp_err=0, rsp_dat=0.
- Read: responder returns 0x1234 with ack -> rsp_dat=0x1234, rsp_err=0. dat_o=0 during the cycle. req_ready low from accept until the rsp_valid cycle.
- Stall: stall high for 3 cycles after stb -> stb high for 4 cycles with adr/we/dat stable. Ack after the transfer completes normally; rsp_valid 3 cycles after stall falls.
- Timeout: TIMEOUT=8, responder never acks -> cyc drops and rsp_valid=1, rsp_err=1, rsp_dat=0 exactly 8 cycles after cyc rose. A later spurious ack produces no response. With ack on the final cycle instead -> normal completion, rsp_err=0.
- Back-to-back: req_valid held with 4 reads (adr 0..3) -> 4 distinct bus cycles in order, 4 rsp_valid pulses with matching data, no overlap of cyc cycles.
- Reset mid-cycle: rst during WAIT -> next cycle cyc=stb=0, rsp_valid=0, req_ready=1. A late ack after reset is ignored.
